// File: rtl/axis_multi_sink_checker.sv
// Sink/scoreboard for N_CH parallel AXI-stream channels: drives TREADY in a selectable
// pattern, checks every accepted beat against a preloaded expected memory, ends on completion or stall.
module axis_multi_sink_checker #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned N_CH      = 5,
  parameter int unsigned DEPTH     = 2304,
  parameter int unsigned PER_LOG2  = 2,
  parameter int unsigned TIMEOUT   = 65535,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                           ap_clk,
  input  logic                                           ap_rst_n,
  input  logic                                           start,
  input  logic [1:0]                                     mode,
  input  logic                                           exp_wr_en,
  input  logic [$clog2(N_CH*DEPTH)-1:0]                  exp_wr_addr,
  input  logic [DATA_W-1:0]                              exp_wr_data,
  input  logic [N_CH*DATA_W-1:0]                         s_tdata,
  input  logic [N_CH-1:0]                                s_tvalid,
  output logic [N_CH-1:0]                                s_tready,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           timed_out,
  output logic [31:0]                                    mismatch_cnt,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]     first_bad_ch,
  output logic [$clog2(DEPTH)-1:0]                       first_bad_idx
);

  localparam int unsigned MEM_N = N_CH * DEPTH;
  localparam int unsigned AW    = $clog2(MEM_N);
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ST_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PC_W  = $clog2(N_CH + 1);
  localparam int unsigned CYC_W = (PER_LOG2 > 0) ? PER_LOG2 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt [N_CH];
  logic [CNT_W-1:0]  cnt_nxt [N_CH];
  logic [ST_W-1:0]   stall, stall_nxt;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [CYC_W-1:0]  cyc;
  logic [N_CH-1:0]   ready_nxt;
  logic              done_nxt, to_nxt;
  logic [31:0]       mm_nxt;
  logic [CH_W-1:0]   fb_ch_nxt;
  logic [IW-1:0]     fb_idx_nxt;
  logic [N_CH-1:0]   acc, bad;
  logic [PC_W-1:0]   pop;
  logic [32:0]       mm_sum;
  logic              all_full;
  logic              per_hit;

  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] rd_data [N_CH];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected memory: writable in any state, reads are combinational so a same-cycle write is not seen.
  always_ff @(posedge ap_clk) begin
    if (exp_wr_en && (32'(exp_wr_addr) < 32'(MEM_N)))
      mem[exp_wr_addr] <= exp_wr_data;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_rd
    logic [CNT_W-1:0] rd_beat;
    assign rd_beat    = (cnt[g] == CNT_W'(DEPTH)) ? '0 : cnt[g];
    assign rd_data[g] = mem[AW'(g * DEPTH) + AW'(rd_beat)];
  end

  assign per_hit = (PER_LOG2 == 0) || (cyc == '0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall_nxt  = stall;
    lfsr_nxt   = lfsr;
    mm_nxt     = mismatch_cnt;
    fb_ch_nxt  = first_bad_ch;
    fb_idx_nxt = first_bad_idx;
    to_nxt     = timed_out;
    done_nxt   = 1'b0;
    ready_nxt  = '0;
    acc        = '0;
    bad        = '0;
    pop        = '0;
    mm_sum     = '0;
    all_full   = 1'b1;

    for (int c = 0; c < N_CH; c++)
      if (cnt[c] != CNT_W'(DEPTH)) all_full = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt  = S_RUN;
          for (int c = 0; c < N_CH; c++) cnt_nxt[c] = '0;
          stall_nxt  = '0;
          mm_nxt     = '0;
          fb_ch_nxt  = '0;
          fb_idx_nxt = '0;
          to_nxt     = 1'b0;
        end
      end
      S_RUN: begin
        lfsr_nxt = lfsr_step(lfsr);
        for (int c = 0; c < N_CH; c++) begin
          acc[c] = s_tvalid[c] & s_tready[c] & (cnt[c] != CNT_W'(DEPTH));
          bad[c] = acc[c] & (s_tdata[c*DATA_W +: DATA_W] != rd_data[c]);
          if (acc[c]) cnt_nxt[c] = cnt[c] + CNT_W'(1);
          pop = pop + PC_W'(bad[c]);
        end
        mm_sum = {1'b0, mismatch_cnt} + 33'(pop);
        mm_nxt = mm_sum[32] ? '1 : mm_sum[31:0];
        // Descending scan so the lowest mismatching channel wins.
        if ((|bad) && (mismatch_cnt == '0)) begin
          for (int c = N_CH - 1; c >= 0; c--) begin
            if (bad[c]) begin
              fb_ch_nxt  = CH_W'(c);
              fb_idx_nxt = IW'(cnt[c]);
            end
          end
        end
        stall_nxt = (|acc) ? '0 : stall + ST_W'(1);
        if (all_full) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (stall == ST_W'(TIMEOUT)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          to_nxt    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Ready for the coming cycle, never for a channel that has already received DEPTH beats.
    if (state_nxt == S_RUN) begin
      for (int c = 0; c < N_CH; c++) begin
        if (cnt_nxt[c] != CNT_W'(DEPTH)) begin
          case (mode)
            2'd0:    ready_nxt[c] = 1'b0;
            2'd1:    ready_nxt[c] = 1'b1;
            2'd2:    ready_nxt[c] = lfsr[c % 16];
            default: ready_nxt[c] = per_hit;
          endcase
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state         <= S_IDLE;
      for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
      stall         <= '0;
      lfsr          <= LFSR_SEED;
      cyc           <= '0;
      s_tready      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      mismatch_cnt  <= '0;
      first_bad_ch  <= '0;
      first_bad_idx <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      stall         <= stall_nxt;
      lfsr          <= lfsr_nxt;
      cyc           <= cyc + CYC_W'(1);
      s_tready      <= ready_nxt;
      busy          <= (state_nxt == S_RUN);
      done          <= done_nxt;
      timed_out     <= to_nxt;
      mismatch_cnt  <= mm_nxt;
      first_bad_ch  <= fb_ch_nxt;
      first_bad_idx <= fb_idx_nxt;
    end
  end

endmodule

// File: tb/tb_axis_multi_sink_checker.sv
// Directed bench for axis_multi_sink_checker with a 2-channel, 4-beat, 20-cycle-timeout build.
module tb_axis_multi_sink_checker;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int DP = 4;
  localparam int TO = 20;

  logic                ap_clk;
  logic                ap_rst_n;
  logic                start;
  logic [1:0]          mode;
  logic                exp_wr_en;
  logic [2:0]          exp_wr_addr;
  logic [DW-1:0]       exp_wr_data;
  logic [NC*DW-1:0]    s_tdata;
  logic [NC-1:0]       s_tvalid;
  logic [NC-1:0]       s_tready;
  logic                busy;
  logic                done;
  logic                timed_out;
  logic [31:0]         mismatch_cnt;
  logic [0:0]          first_bad_ch;
  logic [1:0]          first_bad_idx;

  int n_tests = 0;
  int n_fail  = 0;

  axis_multi_sink_checker #(
    .DATA_W(DW), .N_CH(NC), .DEPTH(DP), .PER_LOG2(2), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .mode(mode),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .busy(busy), .done(done), .timed_out(timed_out), .mismatch_cnt(mismatch_cnt),
    .first_bad_ch(first_bad_ch), .first_bad_idx(first_bad_idx)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected value for channel c, beat b (ch1 beat2 = 5).
  function automatic logic [DW-1:0] exp_val(input int c, input int b);
    return DW'(c * 3 + b);
  endfunction

  // One run: start, stream beats (bad masks corrupt data by +1), stop at done or budget.
  task automatic run(input logic [1:0] md, input bit rnd, input logic [3:0] bad0, input logic [3:0] bad1,
                     output int cyc, output int ndone, output int b0, output int b1, output bit over);
    int bb[NC];
    logic [3:0] msk;
    logic [DW-1:0] d;
    bb = '{0, 0};
    cyc = 0; ndone = 0; over = 1'b0;
    @(negedge ap_clk); start = 1'b1; mode = md; s_tvalid = '0;
    @(negedge ap_clk); start = 1'b0;
    for (int i = 1; i <= 200 && ndone == 0; i++) begin
      for (int c = 0; c < NC; c++) begin
        msk = (c == 0) ? bad0 : bad1;
        d = exp_val(c, bb[c]);
        if (bb[c] < DP && msk[bb[c] % 4]) d = d + DW'(1);
        s_tdata[c*DW +: DW] = d;
        s_tvalid[c] = (bb[c] < DP) && (rnd ? (($urandom & 1) == 1) : 1'b1);
        if (bb[c] == DP && s_tready[c]) over = 1'b1;
        if (s_tvalid[c] && s_tready[c]) bb[c]++;
      end
      @(negedge ap_clk);
      if (done) begin ndone++; cyc = i; end
    end
    s_tvalid = '0;
    @(negedge ap_clk);
    if (done) ndone++;
    b0 = bb[0];
    b1 = bb[1];
  endtask

  int  cyc, nd, b0, b1;
  bit  over;

  initial begin
    ap_rst_n = 1'b0; start = 1'b0; mode = 2'd0;
    exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
    s_tdata = '0; s_tvalid = 2'b11;

    // T1 reset with valid held high
    repeat (3) @(negedge ap_clk);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    check("rst_mismatch", mismatch_cnt, 32'd0);
    check("rst_first_ch", 32'(first_bad_ch), 32'd0);
    check("rst_first_idx", 32'(first_bad_idx), 32'd0);

    // Preload expected memory while reset is still asserted
    s_tvalid = '0;
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < DP; b++) begin
        exp_wr_en = 1'b1; exp_wr_addr = 3'(c * DP + b); exp_wr_data = exp_val(c, b);
        @(negedge ap_clk);
      end
    end
    exp_wr_en = 1'b0;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // T2 mode 1 clean run
    run(2'd1, 1'b0, 4'b0000, 4'b0000, cyc, nd, b0, b1, over);
    check("t2_done_pulses", 32'(nd), 32'd1);
    check("t2_cycles", 32'(cyc), 32'd5);
    check("t2_beats0", 32'(b0), 32'd4);
    check("t2_beats1", 32'(b1), 32'd4);
    check("t2_mismatch", mismatch_cnt, 32'd0);
    check("t2_timed_out", 32'(timed_out), 32'd0);
    check("t2_ready_past_full", 32'(over), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_tready_after", 32'(s_tready), 32'd0);

    // T3 single corruption, ch1 beat2
    run(2'd1, 1'b0, 4'b0000, 4'b0100, cyc, nd, b0, b1, over);
    check("t3_done_pulses", 32'(nd), 32'd1);
    check("t3_mismatch", mismatch_cnt, 32'd1);
    check("t3_first_ch", 32'(first_bad_ch), 32'd1);
    check("t3_first_idx", 32'(first_bad_idx), 32'd2);

    // T3b same-cycle mismatches on both channels, then a later one
    run(2'd1, 1'b0, 4'b0010, 4'b1010, cyc, nd, b0, b1, over);
    check("t3b_mismatch", mismatch_cnt, 32'd3);
    check("t3b_first_ch", 32'(first_bad_ch), 32'd0);
    check("t3b_first_idx", 32'(first_bad_idx), 32'd1);

    // T4 mode 0 always stalls out
    run(2'd0, 1'b0, 4'b0000, 4'b0000, cyc, nd, b0, b1, over);
    check("t4_done_pulses", 32'(nd), 32'd1);
    check("t4_cycles", 32'(cyc), 32'd21);
    check("t4_timed_out", 32'(timed_out), 32'd1);
    check("t4_beats0", 32'(b0), 32'd0);
    check("t4_beats1", 32'(b1), 32'd0);
    check("t4_mismatch", mismatch_cnt, 32'd0);
    check("t4_first_idx_clr", 32'(first_bad_idx), 32'd0);

    // Mode 3: one ready cycle in four
    run(2'd3, 1'b0, 4'b0000, 4'b0000, cyc, nd, b0, b1, over);
    check("per_done_pulses", 32'(nd), 32'd1);
    check("per_timed_out_clr", 32'(timed_out), 32'd0);
    check("per_cycles_ge14", 32'(cyc >= 14), 32'd1);
    check("per_cycles_le17", 32'(cyc <= 17), 32'd1);
    check("per_beats", 32'(b0 + b1), 32'd8);

    // T5 ten back-to-back random runs
    for (int r = 0; r < 10; r++) begin
      run(2'd2, 1'b1, 4'b0000, 4'b0000, cyc, nd, b0, b1, over);
      check($sformatf("t5_r%0d_done", r), 32'(nd), 32'd1);
      check($sformatf("t5_r%0d_mismatch", r), mismatch_cnt, 32'd0);
      check($sformatf("t5_r%0d_timed_out", r), 32'(timed_out), 32'd0);
      check($sformatf("t5_r%0d_beats", r), 32'(b0 * 10 + b1), 32'd44);
      check($sformatf("t5_r%0d_over", r), 32'(over), 32'd0);
    end

    // T6 reset in the middle of a run
    @(negedge ap_clk); start = 1'b1; mode = 2'd1;
    @(negedge ap_clk); start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_tvalid = 2'b11;
      s_tdata  = {exp_val(1, b), exp_val(0, b)};
      @(negedge ap_clk);
    end
    check("t6_busy_mid", 32'(busy), 32'd1);
    s_tvalid = '0;
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_tready_rst", 32'(s_tready), 32'd0);
    check("t6_done_rst", 32'(done), 32'd0);
    ap_rst_n = 1'b1;
    run(2'd1, 1'b0, 4'b0000, 4'b0000, cyc, nd, b0, b1, over);
    check("t6_done_pulses", 32'(nd), 32'd1);
    check("t6_cycles", 32'(cyc), 32'd5);
    check("t6_beats", 32'(b0 + b1), 32'd8);
    check("t6_mismatch", mismatch_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
